// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter with byte/halfword/word
// lane steering, load extension and alignment fault detection.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [1:0]  r0_size,
  input  logic        r0_unsigned,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [1:0]  r1_size,
  input  logic        r1_unsigned,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic        last_r1;
  logic        gnt0, gnt1;
  logic        sel_we, sel_uns, sel_fault;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata, sel_lanes;
  logic        id_q, we_q, uns_q, fault_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] daddr_q, dwdata_q, r0_rdata_q, r1_rdata_q;
  logic [31:0] rd_shift, load_val, resp_data;

  // Grant is combinational in IDLE so that gnt-to-rvalid is two cycles;
  // gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
      if (r0_req && r1_req) begin
        if (last_r1) gnt0 = 1'b1;
        else         gnt1 = 1'b1;
      end else if (r0_req) begin
        gnt0 = 1'b1;
      end else if (r1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we    = gnt1 ? r1_we       : r0_we;
    sel_size  = gnt1 ? r1_size     : r0_size;
    sel_uns   = gnt1 ? r1_unsigned : r0_unsigned;
    sel_addr  = gnt1 ? r1_addr     : r0_addr;
    sel_wdata = gnt1 ? r1_wdata    : r0_wdata;
    sel_fault = (sel_size == 2'b11)
             || (sel_size == 2'b01 && sel_addr[0])
             || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    case (sel_size)
      2'b00:   sel_lanes = {24'b0, sel_wdata[7:0]}  << {sel_addr[1:0], 3'b000};
      2'b01:   sel_lanes = {16'b0, sel_wdata[15:0]} << {sel_addr[1:0], 3'b000};
      2'b10:   sel_lanes = sel_wdata;
      default: sel_lanes = '0;
    endcase
  end

  always_comb begin
    rd_shift = drdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, rd_shift[7:0]}
                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = uns_q ? {16'b0, rd_shift[15:0]}
                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
    resp_data = (we_q || fault_q) ? '0 : load_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt0 || gnt1) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    r0_gnt    = gnt0;
    r1_gnt    = gnt1;
    r0_rvalid = (state == RESP) && !id_q;
    r1_rvalid = (state == RESP) &&  id_q;
    r0_err    = r0_rvalid && fault_q;
    r1_err    = r1_rvalid && fault_q;
    r0_rdata  = r0_rdata_q;
    r1_rdata  = r1_rdata_q;
    daddr     = daddr_q;
    dwdata    = dwdata_q;
    we        = '0;
    if (state == ACCESS && we_q && !fault_q) begin
      case (size_q)
        2'b00:   we = 4'b0001 << off_q;
        2'b01:   we = 4'b0011 << off_q;
        2'b10:   we = 4'b1111;
        default: we = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r1    <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        last_r1  <= gnt1;
        id_q     <= gnt1;
        we_q     <= sel_we;
        uns_q    <= sel_uns;
        fault_q  <= sel_fault;
        size_q   <= sel_size;
        off_q    <= sel_addr[1:0];
        daddr_q  <= {sel_addr[31:2], 2'b00};
        dwdata_q <= sel_fault ? '0 : sel_lanes;
      end
      if (state == ACCESS) begin
        if (id_q) r1_rdata_q <= resp_data;
        else      r0_rdata_q <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a 16-word byte-lane
// memory model attached to the daddr/we/dwdata/drdata port.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        r0_req, r0_we, r0_unsigned, r1_req, r1_we, r1_unsigned;
  logic [1:0]  r0_size, r1_size;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata, daddr, dwdata, drdata;
  logic [3:0]  we;

  logic [31:0] mem [0:15];
  logic        mem_init;
  int unsigned n_cmp, n_bad;
  logic [31:0] exp_last [0:1];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_unsigned(r0_unsigned),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_unsigned(r1_unsigned),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign drdata = mem[daddr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hCAFEF00D;
      mem[1] <= 32'h11223344;
      mem[4] <= 32'h80123456;
    end else begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[daddr[5:2]][8*b +: 8] <= dwdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err}), 32'h0);
    chk({tag, "_r0_rdata"}, r0_rdata, 32'h0);
    chk({tag, "_r1_rdata"}, r1_rdata, 32'h0);
    chk({tag, "_daddr"}, daddr, 32'h0);
    chk({tag, "_dwdata"}, dwdata, 32'h0);
    chk({tag, "_we"}, 32'(we), 32'h0);
  endtask

  task automatic drive(input bit r, input logic req, input logic w, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if (!r) begin
      r0_req = req; r0_we = w; r0_size = sz; r0_unsigned = uns; r0_addr = a; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = w; r1_size = sz; r1_unsigned = uns; r1_addr = a; r1_wdata = wd;
    end
  endtask

  typedef struct {
    bit          r;
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ewe;
    logic [31:0] edw;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t vec [0:13];

  // Called just after a negedge in IDLE; returns just after a negedge back in IDLE.
  task automatic run_txn(input vec_t v, input string name);
    bit got;
    logic g, og, rv, orv, er, oer;
    logic [31:0] rd, ord;
    got = 0;
    drive(v.r, 1'b1, v.w, v.sz, v.uns, v.addr, v.wdata);
    #1;
    for (int k = 0; k < 8 && !got; k++) begin
      g = v.r ? r1_gnt : r0_gnt;
      if (g) got = 1;
      else begin @(negedge clk); #1; end
    end
    if (!got) begin
      chk({name, "_gnt_timeout"}, 32'h0, 32'h1);
      drive(v.r, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      return;
    end
    og = v.r ? r0_gnt : r1_gnt;
    chk({name, "_other_gnt"}, 32'(og), 32'h0);
    @(posedge clk); #1;
    drive(v.r, 1'b0, ~v.w, ~v.sz, ~v.uns, ~v.addr, ~v.wdata);
    @(negedge clk);
    chk({name, "_we"}, 32'(we), 32'(v.ewe));
    chk({name, "_daddr"}, daddr, v.addr & 32'hFFFFFFFC);
    chk({name, "_dwdata"}, dwdata, v.edw);
    chk({name, "_access_quiet"}, 32'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rv  = v.r ? r1_rvalid : r0_rvalid;  orv = v.r ? r0_rvalid : r1_rvalid;
    er  = v.r ? r1_err    : r0_err;     oer = v.r ? r0_err    : r1_err;
    rd  = v.r ? r1_rdata  : r0_rdata;   ord = v.r ? r0_rdata  : r1_rdata;
    chk({name, "_rvalid"}, 32'(rv), 32'h1);
    chk({name, "_rdata"}, rd, v.erd);
    chk({name, "_err"}, 32'(er), 32'(v.eerr));
    chk({name, "_other_rv_err"}, 32'({orv, oer}), 32'h0);
    chk({name, "_other_hold"}, ord, exp_last[v.r ? 0 : 1]);
    chk({name, "_we_resp"}, 32'(we), 32'h0);
    exp_last[v.r ? 1 : 0] = v.erd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit got, seen;
    int waits;
    n_cmp = 0; n_bad = 0;
    mem_init = 1'b1;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    vec[0]  = '{1, 0, 2'b00, 0, 32'h13, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 0};
    vec[1]  = '{1, 0, 2'b00, 1, 32'h13, 32'h0,        4'b0000, 32'h0,        32'h00000080, 0};
    vec[2]  = '{0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0,        0};
    vec[3]  = '{0, 0, 2'b10, 0, 32'h10, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 0};
    vec[4]  = '{0, 1, 2'b01, 0, 32'h06, 32'hFFFFABCD, 4'b1100, 32'hABCD0000, 32'h0,        0};
    vec[5]  = '{1, 0, 2'b01, 0, 32'h06, 32'h0,        4'b0000, 32'h0,        32'hFFFFABCD, 0};
    vec[6]  = '{1, 0, 2'b01, 1, 32'h06, 32'h0,        4'b0000, 32'h0,        32'h0000ABCD, 0};
    vec[7]  = '{0, 1, 2'b00, 0, 32'h05, 32'h1234565A, 4'b0010, 32'h00005A00, 32'h0,        0};
    vec[8]  = '{0, 0, 2'b10, 0, 32'h04, 32'h0,        4'b0000, 32'h0,        32'hABCD5A44, 0};
    vec[9]  = '{1, 1, 2'b10, 0, 32'h02, 32'h12345678, 4'b0000, 32'h0,        32'h0,        1};
    vec[10] = '{1, 0, 2'b10, 0, 32'h00, 32'h0,        4'b0000, 32'h0,        32'hCAFEF00D, 0};
    vec[11] = '{0, 0, 2'b01, 0, 32'h01, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
    vec[12] = '{0, 0, 2'b11, 0, 32'h08, 32'h0,        4'b0000, 32'h0,        32'h0,        1};
    vec[13] = '{1, 0, 2'b00, 0, 32'h07, 32'h0,        4'b0000, 32'h0,        32'hFFFFFFAB, 0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    mem_init = 1'b0;

    // Both requesters held high from reset: alternate starting with r0.
    rst_n = 1'b1;
    #1;
    for (int t = 0; t < 6; t++) begin
      got = 0; waits = 0;
      for (int k = 0; k < 6 && !got; k++) begin
        if (r0_gnt || r1_gnt) got = 1;
        else begin waits++; @(negedge clk); #1; end
      end
      if (!got) chk("rr_gnt_timeout", 32'h0, 32'h1);
      else begin
        if (t == 0) chk("rr_first_wait", 32'(waits), 32'h0);
        chk("rr_onehot", 32'(r0_gnt + r1_gnt), 32'h1);
        chk("rr_order", 32'(r1_gnt), 32'(t % 2));
        @(posedge clk); #1;
      end
    end
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rr_r0_rdata", r0_rdata, 32'hCAFEF00D);
    chk("rr_r1_rdata", r1_rdata, 32'hCAFEF00D);
    exp_last[0] = 32'hCAFEF00D;
    exp_last[1] = 32'hCAFEF00D;

    for (int i = 0; i < 14; i++) run_txn(vec[i], $sformatf("v%0d", i));

    // Reset asserted mid-ACCESS of a word store: write must be suppressed.
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111);
    #1;
    chk("abort_gnt", 32'(r0_gnt), 32'h1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("abort_we_before", 32'(we), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check_zero("abort");
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem", mem[0], 32'hCAFEF00D);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (r0_rvalid || r1_rvalid || we != 4'b0) seen = 1;
    end
    chk("abort_no_rvalid", 32'(seen), 32'h0);
    chk("abort_mem_after", mem[0], 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
